// File: rtl/spi_slave.sv
// spi_slave: SPI target clocked entirely by i_clk. The external SCLK, MOSI and
// SS pins are oversampled, and the CPU reaches the block through a 4-register
// byte bus (STATUS, DATA_OUT, DATA_IN, CTRL).
// Optional feature: define SPI_SLAVE_RX_FIFO_EN to put an RX_FIFO_DEPTH-entry
// receive FIFO behind DATA_IN. The default build uses a single holding register.
module spi_slave #(
    parameter int CLK_FREQ      = 48_000_000,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_SCLK,
    input  logic       i_MOSI,
    output logic       o_MISO,
    output logic       o_MISO_oe,
    input  logic       i_SS,
    input  logic       i_en,
    input  logic       i_wr,
    input  logic [3:0] i_addr,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_int
);

    localparam logic [3:0] A_STATUS = 4'd0;
    localparam logic [3:0] A_DOUT   = 4'd1;
    localparam logic [3:0] A_DIN    = 4'd2;
    localparam logic [3:0] A_CTRL   = 4'd3;

    // Reject parameter values the block is not built for. SCLK must stay at or
    // below CLK_FREQ/8, so anything slower than 8 Hz cannot be meaningful.
    if (CLK_FREQ < 8 || RX_FIFO_DEPTH < 2 || RX_FIFO_DEPTH > 8 ||
        (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_param_chk
        $error("spi_slave: unsupported CLK_FREQ or RX_FIFO_DEPTH");
    end

    typedef enum logic [0:0] {IDLE, SEL} state_t;

    state_t     state;
    logic [2:0] sclk_q;
    logic [1:0] mosi_q;
    logic [2:0] ss_q;
    logic [3:0] ctrl;
    logic [7:0] data_out;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sr;
    logic [7:0] tx_sr;
    logic       tx_empty;
    logic       rx_ovr;

    logic       cpha, cpol, en, ie;
    logic       sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
    logic       ss_act, ss_fall, enter, stay;
    logic       byte_done, accept, ovr_set;
    logic [7:0] rx_byte;
    logic       rd_stb, wr_stb, rd_din, wr_dout;
    logic       rx_avail;
    logic [7:0] din_head;
    logic [3:0] rx_cnt4;
    logic [7:0] status;

    assign cpha = ctrl[0];
    assign cpol = ctrl[1];
    assign en   = ctrl[2];
    assign ie   = ctrl[3];

    // Edges come from the 2nd/3rd SCLK stages; MOSI's 2nd stage lines up with them.
    assign sclk_edge   = sclk_q[1] ^ sclk_q[2];
    assign lead_edge   = sclk_edge & (sclk_q[2] == cpol);
    assign trail_edge  = sclk_edge & (sclk_q[2] != cpol);
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge  : trail_edge;

    assign ss_act  = ~ss_q[1];
    assign ss_fall = ss_q[2] & ~ss_q[1];
    assign enter   = (state == IDLE) & ss_fall & en;
    assign stay    = ss_act & en;

    assign rx_byte   = {rx_sr, mosi_q[1]};
    assign byte_done = (state == SEL) & stay & sample_edge & (bit_cnt == 3'd7);
    assign ovr_set   = byte_done & ~accept;

    assign rd_stb  = i_en & ~i_wr;
    assign wr_stb  = i_en & i_wr;
    assign rd_din  = rd_stb & (i_addr == A_DIN);
    assign wr_dout = wr_stb & (i_addr == A_DOUT);

    assign status = {rx_cnt4, tx_empty, rx_ovr, rx_avail, ss_act & en};

    // Pin synchronisers. SS resets to "asserted" so that a select held low
    // through reset cannot start a transfer until it is released and reasserted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sclk_q <= '0;
            mosi_q <= '0;
            ss_q   <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], i_SCLK};
            mosi_q <= {mosi_q[0], i_MOSI};
            ss_q   <= {ss_q[1:0], i_SS};
        end
    end

    // Transfer FSM: shift registers, bit counter and MISO drive.
    // tx_sr always holds the bits still to be driven, MSB first; in CPHA=0 the
    // MSB goes out on entry, so tx_sr starts pre-shifted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            o_MISO    <= 1'b0;
            o_MISO_oe <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_MISO_oe <= 1'b0;
                    if (enter) begin
                        state     <= SEL;
                        o_MISO_oe <= 1'b1;
                        bit_cnt   <= '0;
                        if (cpha) begin
                            tx_sr <= data_out;
                        end else begin
                            tx_sr  <= {data_out[6:0], 1'b0};
                            o_MISO <= data_out[7];
                        end
                    end
                end
                SEL: begin
                    if (!stay) begin
                        state     <= IDLE;
                        o_MISO_oe <= 1'b0;
                        bit_cnt   <= '0;
                    end else if (sample_edge) begin
                        rx_sr   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            tx_sr <= data_out;
                    end else if (shift_edge) begin
                        o_MISO <= tx_sr[7];
                        tx_sr  <= {tx_sr[6:0], 1'b0};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // CPU-written registers and the tx_empty / rx_ovr flags.
    // A DATA_OUT write wins over a same-cycle tx load, leaving tx_empty at 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ctrl     <= '0;
            data_out <= '0;
            tx_empty <= 1'b1;
            rx_ovr   <= 1'b0;
        end else begin
            if (wr_stb && i_addr == A_CTRL)
                ctrl <= i_data[3:0];
            if (wr_dout)
                data_out <= i_data;
            if (wr_dout)
                tx_empty <= 1'b0;
            else if (enter || byte_done)
                tx_empty <= 1'b1;
            if (ovr_set)
                rx_ovr <= 1'b1;
            else if (wr_stb && i_addr == A_STATUS && i_data[2])
                rx_ovr <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_RX_FIFO_EN
    localparam int PW = $clog2(RX_FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    fifo_mem [RX_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] rx_count;
    logic          fifo_full, pop;

    assign fifo_full = (rx_count == CW'(RX_FIFO_DEPTH));
    assign pop       = rd_din & (rx_count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign accept    = byte_done & (~fifo_full | pop);
    assign rx_avail  = (rx_count != '0);
    assign din_head  = rx_avail ? fifo_mem[rd_ptr] : 8'h00;
    assign rx_cnt4   = 4'(rx_count);

    // FIFO pointers and occupancy.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // FIFO storage; contents are qualified by rx_count, so no reset needed.
    always_ff @(posedge i_clk) begin
        if (accept)
            fifo_mem[wr_ptr] <= rx_byte;
    end
`else
    logic [7:0] data_in;
    logic       rx_full;

    // A read in the same cycle as completion frees the register for the new byte.
    assign accept   = byte_done & (~rx_full | rd_din);
    assign rx_avail = rx_full;
    assign din_head = data_in;
    assign rx_cnt4  = 4'd0;

    // Single DATA_IN holding register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_in <= '0;
            rx_full <= 1'b0;
        end else begin
            if (accept) begin
                data_in <= rx_byte;
                rx_full <= 1'b1;
            end else if (rd_din) begin
                rx_full <= 1'b0;
            end
        end
    end
`endif

    // Registered read data and the completion interrupt.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data <= '0;
            o_int  <= 1'b0;
        end else begin
            o_int <= accept & ie;
            if (rd_stb) begin
                case (i_addr)
                    A_STATUS: o_data <= status;
                    A_DOUT:   o_data <= data_out;
                    A_DIN:    o_data <= din_head;
                    A_CTRL:   o_data <= {4'd0, ctrl};
                    default:  o_data <= 8'h00;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: acts as an SPI master on the pins and as the
// CPU on the register bus, checking hand-computed values.
module tb_spi_slave;

    localparam int HALF = 8;   // SCLK half period in i_clk cycles
`ifdef SPI_SLAVE_RX_FIFO_EN
    localparam logic [7:0] CNT1 = 8'h10;
`else
    localparam logic [7:0] CNT1 = 8'h00;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_SCLK, i_MOSI, i_SS;
    logic       o_MISO, o_MISO_oe;
    logic       i_en, i_wr;
    logic [3:0] i_addr;
    logic [7:0] i_data, o_data;
    logic       o_int;

    int   n_chk = 0;
    int   n_fail = 0;
    int   int_total = 0;
    int   base;
    logic cpol = 1'b0;
    logic cpha = 1'b0;
    logic [7:0] rd, got;

    spi_slave #(.CLK_FREQ(48_000_000), .RX_FIFO_DEPTH(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_SCLK(i_SCLK), .i_MOSI(i_MOSI),
        .o_MISO(o_MISO), .o_MISO_oe(o_MISO_oe), .i_SS(i_SS), .i_en(i_en),
        .i_wr(i_wr), .i_addr(i_addr), .i_data(i_data), .o_data(o_data),
        .o_int(o_int)
    );

    always #5 i_clk = ~i_clk;

    // Count interrupt pulses away from the active edge.
    always @(negedge i_clk) if (o_int === 1'b1) int_total++;

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_chk++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge i_clk);
        i_en = 1'b1; i_wr = 1'b1; i_addr = a; i_data = d;
        @(negedge i_clk);
        i_en = 1'b0; i_wr = 1'b0;
    endtask

    task automatic cpu_rd(input logic [3:0] a, output logic [7:0] d);
        @(negedge i_clk);
        i_en = 1'b1; i_wr = 1'b0; i_addr = a;
        @(negedge i_clk);
        i_en = 1'b0;
        d = o_data;
    endtask

    task automatic ss_low();
        i_SS = 1'b0;
        wait_clk(6);
    endtask

    task automatic ss_high();
        i_SS = 1'b1;
        i_MOSI = 1'b0;
        wait_clk(6);
    endtask

    // Drive n SCLK edges in the current mode, shifting out tx and sampling MISO
    // on the master's sample edges.
    task automatic spi_edges(input logic [7:0] tx, input int n, output logic [7:0] rx);
        int   nb;
        logic lead;
        nb = 0;
        rx = 8'h00;
        if (!cpha) begin
            i_MOSI = tx[7];
            nb = 1;
        end
        for (int e = 0; e < n; e++) begin
            wait_clk(HALF);
            lead = ((e % 2) == 0);
            if (lead != cpha) rx = {rx[6:0], o_MISO};
            i_SCLK = ~i_SCLK;
            if (lead == cpha && nb < 8) begin
                i_MOSI = tx[7 - nb];
                nb++;
            end
        end
        wait_clk(HALF);
    endtask

    initial begin
        i_rst = 1'b1; i_SCLK = 1'b0; i_MOSI = 1'b0; i_SS = 1'b1;
        i_en = 1'b0; i_wr = 1'b0; i_addr = '0; i_data = '0;
        wait_clk(3);
        i_rst = 1'b0;
        wait_clk(4);

        // Reset state
        chk("rst_o_data", o_data, 8'h00);
        chk("rst_o_int", o_int, 1'b0);
        chk("rst_miso", o_MISO, 1'b0);
        chk("rst_oe", o_MISO_oe, 1'b0);
        cpu_rd(4'd0, rd); chk("rst_status", rd, 8'h08);
        cpu_rd(4'd3, rd); chk("rst_ctrl", rd, 8'h00);
        cpu_rd(4'd2, rd); chk("rst_din", rd, 8'h00);

        // Mode 0 single byte
        cpu_wr(4'd3, 8'h0C);
        cpu_wr(4'd1, 8'hA5);
        cpu_rd(4'd0, rd); chk("t1_status_pre", rd, 8'h00);
        cpu_wr(4'd7, 8'hFF);
        cpu_rd(4'd7, rd); chk("unmapped_rd", rd, 8'h00);
        base = int_total;
        ss_low();
        chk("t1_oe", o_MISO_oe, 1'b1);
        spi_edges(8'h3C, 16, got);
        chk("t1_miso", got, 8'hA5);
        chk("t1_int", int_total - base, 1);
        cpu_rd(4'd0, rd); chk("t1_status", rd, 8'h0B | CNT1);
        cpu_rd(4'd2, rd); chk("t1_din", rd, 8'h3C);
        cpu_rd(4'd0, rd); chk("t1_status_post", rd, 8'h09);
        ss_high();
        chk("t1_oe_off", o_MISO_oe, 1'b0);

        // Modes 1..3
        for (int m = 1; m < 4; m++) begin
            cpol = m[1]; cpha = m[0];
            i_SCLK = cpol;
            wait_clk(4);
            cpu_wr(4'd3, 8'h04 | 8'(m));
            cpu_wr(4'd1, 8'h81);
            ss_low();
            spi_edges(8'h7E, 16, got);
            chk($sformatf("t2_m%0d_miso", m), got, 8'h81);
            cpu_rd(4'd2, rd); chk($sformatf("t2_m%0d_din", m), rd, 8'h7E);
            ss_high();
        end
        cpol = 1'b0; cpha = 1'b0; i_SCLK = 1'b0;
        wait_clk(4);
        cpu_wr(4'd3, 8'h0C);

`ifdef SPI_SLAVE_RX_FIFO_EN
        // FIFO overrun: five bytes into a depth-4 FIFO
        base = int_total;
        ss_low();
        for (int b = 1; b <= 5; b++) spi_edges(8'(b), 16, got);
        chk("t6_int", int_total - base, 4);
        cpu_rd(4'd0, rd); chk("t6_status_full", rd, 8'h4F);
        for (int b = 1; b <= 4; b++) begin
            cpu_rd(4'd2, rd); chk($sformatf("t6_din%0d", b), rd, 8'(b));
        end
        cpu_rd(4'd0, rd); chk("t6_status_empty", rd, 8'h0D);
        cpu_rd(4'd2, rd); chk("t6_din_empty", rd, 8'h00);
        cpu_wr(4'd0, 8'h04);
        cpu_rd(4'd0, rd); chk("t6_ovr_clr", rd, 8'h09);
        ss_high();
`else
        // Overrun with the single holding register
        cpu_wr(4'd1, 8'h11);
        base = int_total;
        ss_low();
        spi_edges(8'h5A, 16, got); chk("t3_miso0", got, 8'h11);
        spi_edges(8'hC3, 16, got); chk("t3_miso1_stale", got, 8'h11);
        chk("t3_int", int_total - base, 1);
        cpu_rd(4'd0, rd); chk("t3_status", rd, 8'h0F);
        cpu_rd(4'd2, rd); chk("t3_din", rd, 8'h5A);
        cpu_wr(4'd0, 8'h04);
        cpu_rd(4'd0, rd); chk("t3_ovr_clr", rd, 8'h09);
        ss_high();
`endif

        // SS released mid-byte
        cpu_wr(4'd1, 8'h96);
        base = int_total;
        ss_low();
        spi_edges(8'hFF, 5, got);
        ss_high();
        i_SCLK = 1'b0;
        wait_clk(4);
        chk("t4_int", int_total - base, 0);
        chk("t4_oe", o_MISO_oe, 1'b0);
        cpu_rd(4'd0, rd); chk("t4_status", rd, 8'h08);
        ss_low();
        spi_edges(8'h69, 16, got);
        chk("t4_miso", got, 8'h96);
        chk("t4_int_full", int_total - base, 1);
        cpu_rd(4'd2, rd); chk("t4_din", rd, 8'h69);
        ss_high();

        // Reset mid-byte
        cpu_wr(4'd1, 8'h5A);
        ss_low();
        spi_edges(8'hAB, 4, got);
        cpu_rd(4'd1, rd); chk("t5_dout_rb", rd, 8'h5A);
        @(negedge i_clk); i_rst = 1'b1;
        wait_clk(2);
        i_rst = 1'b0;
        wait_clk(1);
        chk("t5_o_data", o_data, 8'h00);
        chk("t5_o_int", o_int, 1'b0);
        chk("t5_miso", o_MISO, 1'b0);
        chk("t5_oe", o_MISO_oe, 1'b0);
        cpu_rd(4'd0, rd); chk("t5_status", rd, 8'h08);
        cpu_wr(4'd3, 8'h0C);
        base = int_total;
        spi_edges(8'hAB, 16, got);
        chk("t5_no_int", int_total - base, 0);
        chk("t5_oe_held", o_MISO_oe, 1'b0);
        cpu_rd(4'd0, rd); chk("t5_status_held", rd, 8'h09);
        ss_high();
        ss_low();
        spi_edges(8'h42, 16, got);
        chk("t5_miso_after", got, 8'h00);
        chk("t5_int_after", int_total - base, 1);
        cpu_rd(4'd2, rd); chk("t5_din_after", rd, 8'h42);
        ss_high();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
